step_gen_q: RTL and testbench

//  Parametrised step/dir pulse generator, successor to the single-pulse step generator.
//  - A phase accumulator, advanced by a signed velocity, produces step events.
//  - Events are queued in a signed pending counter instead of being dropped while a pulse is in flight.
//  - A pulse FSM with runtime setup/high/hold timing replays the queue to the driver pins.
//  - Tracks absolute position; sits between the motion planner registers and one motor-driver channel.

---
 rtl/step_gen_q.sv | 183 ++++++++++++++++++
 tb/tb_step_gen_q.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/step_gen_q.sv
// step_gen_q: phase-accumulator step/dir pulse generator with a signed step queue.
// The accumulator emits one step event each time its MSB toggles. Events are
// counted in a saturating signed pending counter, and a pulse FSM plays the queue
// out to the driver pins using runtime setup/high/hold timing.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no pulse in flight; starts one when pending != 0
//   SETUP | dir driven, step inactive, waiting max(t_setup,1) cycles
//   HIGH  | step active for max(t_high,1) cycles
//   HOLD  | step inactive, dir held for max(t_hold,1) cycles, then position update
module step_gen_q #(
  parameter int ACC_W        = 32,
  parameter int POS_W        = 32,
  parameter int CNT_W        = 10,
  parameter int PEND_W       = 4,
  parameter int STEP_ACT_LOW = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ACC_W-1:0]  velocity,
  input  logic              set_position,
  input  logic [POS_W-1:0]  data_in,
  input  logic [CNT_W-1:0]  t_setup,
  input  logic [CNT_W-1:0]  t_high,
  input  logic [CNT_W-1:0]  t_hold,
  input  logic              clr_err,
  output logic [POS_W-1:0]  position,
  output logic [ACC_W-1:0]  acc,
  output logic [PEND_W-1:0] pending,
  output logic              step,
  output logic              dir,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

  localparam logic signed [PEND_W+1:0] P_ONE = (PEND_W+2)'(1);
  localparam logic signed [PEND_W+1:0] P_MAX = (PEND_W+2)'(2**(PEND_W-1)-1);
  localparam logic signed [PEND_W+1:0] P_MIN = -P_MAX;

  state_t                    state_q, state_d;
  logic [ACC_W-1:0]          acc_q, acc_d, acc_sum;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic signed [PEND_W-1:0]  pend_q, pend_d;
  logic signed [PEND_W+1:0]  pend_ext, ev_delta, cons_delta, pend_sum, pend_keep;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      dir_q, dir_d;
  logic                      step_act_q, step_act_d;
  logic                      overrun_q, overrun_d;
  logic                      discard_q, discard_d;
  logic                      adv, ev, ev_rev, ovf, cons, pulse_done;

  // zero timing values are stretched to a single cycle
  function automatic logic [CNT_W-1:0] at_least1(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_W'(1) : t;
  endfunction

  // accumulator advance and step-event detection on MSB toggle
  always_comb begin
    adv     = enable & ~set_position;
    acc_sum = acc_q + velocity;
    ev      = adv && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
    ev_rev  = velocity[ACC_W-1];
    acc_d   = acc_q;
    if (set_position) acc_d = '0;
    else if (adv)     acc_d = acc_sum;
  end

  // pulse FSM: next state, down-counter reload and pin levels
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    step_act_d = step_act_q;
    discard_d  = discard_q;
    cons       = 1'b0;
    pulse_done = 1'b0;
    case (state_q)
      IDLE: begin
        step_act_d = 1'b0;
        if (pend_q != '0 && !set_position) begin
          dir_d     = pend_q[PEND_W-1];
          cons      = 1'b1;
          cnt_d     = at_least1(t_setup);
          discard_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          step_act_d = 1'b1;
          cnt_d      = at_least1(t_high);
          state_d    = HIGH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HIGH: begin
        if (cnt_q == CNT_W'(1)) begin
          step_act_d = 1'b0;
          cnt_d      = at_least1(t_hold);
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(1)) begin
          pulse_done = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        step_act_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
    // a position load while a pulse is in flight voids that pulse's position update
    if (set_position && state_q != IDLE) discard_d = 1'b1;
  end

  // pending queue, overrun flag and position bookkeeping
  always_comb begin
    pend_ext   = {{2{pend_q[PEND_W-1]}}, pend_q};
    ev_delta   = ev ? (ev_rev ? -P_ONE : P_ONE) : '0;
    cons_delta = cons ? (pend_q[PEND_W-1] ? -P_ONE : P_ONE) : '0;
    pend_keep  = pend_ext - cons_delta;
    pend_sum   = pend_keep + ev_delta;
    ovf        = ev && (pend_sum > P_MAX || pend_sum < P_MIN);

    pend_d = pend_sum[PEND_W-1:0];
    if (set_position) pend_d = '0;
    else if (ovf)     pend_d = pend_keep[PEND_W-1:0];

    overrun_d = overrun_q;
    if (set_position) overrun_d = 1'b0;
    else if (ovf)     overrun_d = 1'b1;
    else if (clr_err) overrun_d = 1'b0;

    pos_d = pos_q;
    if (set_position)                   pos_d = data_in;
    else if (pulse_done && !discard_q)  pos_d = dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
  end

  // state registers; async reset forces step inactive immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      pos_q      <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      step_act_q <= 1'b0;
      overrun_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pos_q      <= pos_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      step_act_q <= step_act_d;
      overrun_q  <= overrun_d;
      discard_q  <= discard_d;
    end
  end

  assign position = pos_q;
  assign acc      = acc_q;
  assign pending  = pend_q;
  assign step     = step_act_q ^ (STEP_ACT_LOW != 0);
  assign dir      = dir_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_step_gen_q.sv
// Directed bench for step_gen_q (default parameters, step active high).
module tb_step_gen_q;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable, set_position, clr_err;
  logic [31:0] velocity, data_in;
  logic [9:0]  t_setup, t_high, t_hold;
  logic [31:0] position, acc;
  logic [3:0]  pending;
  logic        step, dir, busy, overrun;

  int n_chk  = 0;
  int n_pass = 0;

  step_gen_q dut (
    .clk(clk), .reset(reset), .enable(enable), .velocity(velocity),
    .set_position(set_position), .data_in(data_in),
    .t_setup(t_setup), .t_high(t_high), .t_hold(t_hold), .clr_err(clr_err),
    .position(position), .acc(acc), .pending(pending), .step(step),
    .dir(dir), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input logic lvl, input int budget, input string tag);
    int k = 0;
    while (step !== lvl && k < budget) begin tick(1); k++; end
    check(tag, 64'(step === lvl), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((busy !== 1'b0 || pending !== 4'd0) && k < budget) begin tick(1); k++; end
    check(tag, 64'(busy === 1'b0 && pending === 4'd0), 64'd1);
  endtask

  // leaves the bench on the first sample of the following pulse
  task automatic measure(output int hi, output int per);
    wait_step(1'b0, 64, "m_low");
    wait_step(1'b1, 64, "m_rise");
    hi = 0;
    while (step === 1'b1 && hi < 64) begin tick(1); hi++; end
    per = hi;
    while (step === 1'b0 && per < 200) begin tick(1); per++; end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; set_position = 1'b0; clr_err = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    int hi, per, su, k;
    logic seen;
    enable = 1'b0; set_position = 1'b0; clr_err = 1'b0;
    velocity = '0; data_in = '0; t_setup = '0; t_high = '0; t_hold = '0;
    tick(2);
    check("rst_pos",  64'(position), 64'd0);
    check("rst_acc",  64'(acc),      64'd0);
    check("rst_pend", 64'(pending),  64'd0);
    check("rst_step", 64'(step),     64'd0);
    check("rst_dir",  64'(dir),      64'd0);
    check("rst_busy", 64'(busy),     64'd0);
    check("rst_ovr",  64'(overrun),  64'd0);
    reset = 1'b0;
    tick(1);

    // forward, 2/3/2 timing, 12 enabled cycles -> 6 events
    t_setup = 10'd2; t_high = 10'd3; t_hold = 10'd2;
    velocity = 32'h4000_0000;
    enable = 1'b1;
    tick(12);
    enable = 1'b0;
    measure(hi, per);
    check("fwd_high",   64'(hi),  64'd3);
    check("fwd_period", 64'(per), 64'd8);
    check("fwd_dir",    64'(dir), 64'd0);
    wait_idle(300, "fwd_drain");
    check("fwd_pos",  64'(position), 64'd6);
    check("fwd_acc",  64'(acc),      64'd0);
    check("fwd_ovr",  64'(overrun),  64'd0);

    // saturate the queue while the FSM is parked in a very long HIGH
    do_reset();
    t_setup = 10'd2; t_high = 10'd1023; t_hold = 10'd2;
    velocity = 32'h4000_0000;
    enable = 1'b1;
    k = 0;
    while (overrun !== 1'b1 && k < 100) begin tick(1); k++; end
    check("ovr_set",  64'(overrun), 64'd1);
    check("ovr_pend", 64'(pending), 64'd7);
    enable = 1'b0;
    tick(3);
    check("ovr_sticky", 64'(overrun), 64'd1);
    check("ovr_hold7",  64'(pending), 64'd7);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovr_clr",   64'(overrun), 64'd0);
    check("ovr_pend2", 64'(pending), 64'd7);
    enable = 1'b1; clr_err = 1'b1; seen = 1'b0;
    repeat (4) begin tick(1); if (overrun === 1'b1) seen = 1'b1; end
    enable = 1'b0; clr_err = 1'b0;
    check("clr_vs_ovf", 64'(seen), 64'd1);
    check("pre_rst_step", 64'(step), 64'd1);
    reset = 1'b1;
    #1;
    check("arst_step", 64'(step),    64'd0);
    check("arst_busy", 64'(busy),    64'd0);
    check("arst_pend", 64'(pending), 64'd0);
    check("arst_ovr",  64'(overrun), 64'd0);
    check("arst_acc",  64'(acc),     64'd0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // reverse from position 5
    t_setup = 10'd2; t_high = 10'd3; t_hold = 10'd2;
    data_in = 32'd5; set_position = 1'b1;
    tick(1);
    set_position = 1'b0;
    check("rev_load", 64'(position), 64'd5);
    velocity = 32'hC000_0000;
    enable = 1'b1;
    su = 0; k = 0;
    while (step !== 1'b1 && k < 30) begin
      tick(1); k++;
      if (k == 4) enable = 1'b0;
      if (step === 1'b0 && dir === 1'b1) su++;
    end
    enable = 1'b0;
    check("rev_setup", 64'(su),       64'd2);
    check("rev_dir",   64'(dir),      64'd1);
    check("rev_pos0",  64'(position), 64'd5);
    wait_idle(300, "rev_drain");
    check("rev_pos", 64'(position), 64'd3);

    // queued forward steps cancelled by reverse events
    do_reset();
    t_setup = 10'd2; t_high = 10'd20; t_hold = 10'd2;
    velocity = 32'h4000_0000;
    enable = 1'b1;
    tick(8);
    check("cx_pend3", 64'(pending), 64'd3);
    check("cx_busy",  64'(busy),    64'd1);
    velocity = 32'hC000_0000;
    tick(1);
    check("cx_pend2", 64'(pending), 64'd2);
    tick(2);
    check("cx_pend1", 64'(pending), 64'd1);
    tick(4);
    check("cx_pendm1", 64'(pending), 64'hF);
    enable = 1'b0;
    check("cx_dir_inflight", 64'(dir),  64'd0);
    check("cx_step",         64'(step), 64'd1);
    wait_idle(300, "cx_drain");
    check("cx_pos", 64'(position), 64'd0);
    check("cx_dir", 64'(dir),      64'd1);

    // position load during HIGH
    do_reset();
    t_setup = 10'd2; t_high = 10'd3; t_hold = 10'd2;
    velocity = 32'h4000_0000;
    enable = 1'b1;
    tick(2);
    enable = 1'b0;
    wait_step(1'b1, 20, "sp_rise");
    hi = 1;
    data_in = 32'd100; set_position = 1'b1;
    tick(1);
    set_position = 1'b0;
    check("sp_loaded", 64'(position), 64'd100);
    while (step === 1'b1 && hi < 20) begin hi++; tick(1); end
    check("sp_high", 64'(hi), 64'd3);
    wait_idle(100, "sp_drain");
    check("sp_pos",  64'(position), 64'd100);
    check("sp_pend", 64'(pending),  64'd0);
    check("sp_acc",  64'(acc),      64'd0);

    // zero timing: one cycle per phase, then async reset in HIGH
    do_reset();
    t_setup = 10'd0; t_high = 10'd0; t_hold = 10'd0;
    velocity = 32'h4000_0000;
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    measure(hi, per);
    check("z_high",   64'(hi),       64'd1);
    check("z_period", 64'(per),      64'd4);
    check("z_pos",    64'(position), 64'd2);
    check("z_step",   64'(step),     64'd1);
    reset = 1'b1;
    #1;
    check("z_arst_step", 64'(step),     64'd0);
    check("z_arst_pos",  64'(position), 64'd0);
    check("z_arst_busy", 64'(busy),     64'd0);
    check("z_arst_dir",  64'(dir),      64'd0);
    tick(1);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
